// File: rtl/mult_job_sequencer_if.sv
// ---------------------------------------------------------------------------
// mult_job_sequencer_if
// Purpose: operand-in and product-out streaming channels of the multiplier
//          job sequencer, bundled so source and sink connect through one port.
// Handshake: a beat moves on a rising clk edge where valid & ready are both 1.
//   A producer raising valid keeps valid and data unchanged until that edge.
//   ready may change freely and carries no data meaning on its own.
// Signals:
//   in_valid/in_ready/in_a/in_b     operand pair channel (master -> slave)
//   out_valid/out_ready/out_product product channel (slave -> master)
// Modports: master = job source / result sink, slave = sequencer.
// ---------------------------------------------------------------------------
interface mult_job_sequencer_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/mult_job_sequencer.sv
// ---------------------------------------------------------------------------
// mult_job_sequencer
// Purpose: front-end for the constant-time sequential multiplier. Queues
//   operand pairs in a DEPTH-entry FIFO, issues one job at a time (operands
//   held on the load buses, one-cycle start pulse), waits for the done pulse,
//   captures the 2*WIDTH-bit product and offers it on the result channel.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   bus (slave)     operand in / product out valid-ready channels
//   mult_start      one-cycle start pulse to the multiplier controller
//   mult_mcand/mult_mplier  operands, stable for the whole job
//   mult_done       done pulse from the controller (honoured only in WAIT)
//   mult_product    datapath result register
//   fifo_count      entries currently queued
//   err_timeout     sticky: done pulse never arrived within TIMEOUT cycles
//   o_dbg_state     current FSM state
// ---------------------------------------------------------------------------
module mult_job_sequencer #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4*WIDTH+4
) (
  input  logic                          clk,
  input  logic                          rst,
  mult_job_sequencer_if.slave           bus,
  output logic                          mult_start,
  output logic [WIDTH-1:0]              mult_mcand,
  output logic [WIDTH-1:0]              mult_mplier,
  input  logic                          mult_done,
  input  logic [2*WIDTH-1:0]            mult_product,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic                          err_timeout,
  output logic [2:0]                    o_dbg_state
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [WDW-1:0]       r_watchdog;
  logic                 r_start;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_out_valid;
  logic [2*WIDTH-1:0]   r_out_product;
  logic                 r_err_timeout;

  logic                 w_in_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [2*WIDTH-1:0]   w_head;

  // Readiness depends only on the registered count: a full FIFO does not
  // accept even if the head is being popped in the same cycle.
  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // Operand FIFO. Pointers are AW bits wide so they wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Job FSM; every output is registered and set on the transition into the
  // state where it must be visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_start       <= 1'b0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_out_valid   <= 1'b0;
      r_out_product <= '0;
      r_err_timeout <= 1'b0;
      r_watchdog    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_mcand  <= w_head[2*WIDTH-1:WIDTH];
            r_mplier <= w_head[WIDTH-1:0];
            r_start  <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_start    <= 1'b0;
          r_watchdog <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          r_watchdog <= r_watchdog + WDW'(1);
          if (mult_done) begin
            r_state <= S_CAPTURE;
          end else if (r_watchdog == WDW'(TIMEOUT - 1)) begin
            // Done pulse lost: drop the job rather than stall the queue.
            r_err_timeout <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          // The multiplier's final shift landed on the previous edge.
          r_out_product <= mult_product;
          r_out_valid   <= 1'b1;
          r_state       <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_product = r_out_product;
  assign mult_start      = r_start;
  assign mult_mcand      = r_mcand;
  assign mult_mplier     = r_mplier;
  assign fifo_count      = r_count;
  assign err_timeout     = r_err_timeout;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_mult_job_sequencer.sv
module tb_mult_job_sequencer;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HOLD = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_job_sequencer_if #(.WIDTH(W)) bus ();

  logic           mult_start;
  logic [W-1:0]   mult_mcand;
  logic [W-1:0]   mult_mplier;
  logic           mult_done;
  logic [2*W-1:0] mult_product;
  logic [CW-1:0]  fifo_count;
  logic           err_timeout;
  logic [2:0]     dbg_state;

  mult_job_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_done    (mult_done),
    .mult_product (mult_product),
    .fifo_count   (fifo_count),
    .err_timeout  (err_timeout),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- multiplier model ----------------
  // Done pulse 2*W edges after start is sampled; product presented with it.
  logic       drop_done;
  logic       spur_done;
  logic       m_done;
  logic [4:0] m_cnt;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (mult_start) begin
        m_cnt <= 5'd1;
      end else if (m_cnt == 5'(2*W)) begin
        m_cnt        <= '0;
        m_done       <= !drop_done;
        mult_product <= 8'(mult_mcand) * 8'(mult_mplier);
      end else if (m_cnt != '0) begin
        m_cnt <= m_cnt + 5'd1;
      end
    end
  end
  assign mult_done = m_done | spur_done;

  // Start-pulse monitor: counts pulses and flags any pulse longer than 1 cycle.
  int start_cnt = 0;
  int start_dbl = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mult_start) start_cnt++;
      if (mult_start && prev_start) start_dbl++;
      prev_start = mult_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] p);
    int k;
    for (k = 0; k < 200 && !bus.in_ready; k++) tick();
    if (!bus.in_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back(p);
  endtask

  task automatic wait_out_valid(input string name);
    int k;
    for (k = 0; k < 200 && !bus.out_valid; k++) tick();
    if (!bus.out_valid) check({name, "_valid_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic collect(input string name);
    logic [2*W-1:0] e;
    wait_out_valid(name);
    if (!bus.out_valid) return;
    if (exp_q.size() == 0) begin
      check({name, "_unexpected"}, 32'(bus.out_product), 32'hFFFF);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(bus.out_product), 32'(e));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t corner_v[6];
  vec_t fill_v[5];

  initial begin
    int n;
    int first_start;
    int st0;
    int bad;
    logic [2*W-1:0] snap;

    corner_v[0] = '{4'd15, 4'd15, 8'd225};
    corner_v[1] = '{4'd0,  4'd9,  8'd0};
    corner_v[2] = '{4'd1,  4'd1,  8'd1};
    corner_v[3] = '{4'd8,  4'd0,  8'd0};
    corner_v[4] = '{4'd13, 4'd11, 8'd143};
    corner_v[5] = '{4'd7,  4'd9,  8'd63};
    fill_v[0]   = '{4'd2,  4'd3,  8'd6};
    fill_v[1]   = '{4'd5,  4'd5,  8'd25};
    fill_v[2]   = '{4'd9,  4'd7,  8'd63};
    fill_v[3]   = '{4'd12, 4'd10, 8'd120};
    fill_v[4]   = '{4'd14, 4'd13, 8'd182};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b0;
    drop_done = 1'b0;
    spur_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // ---- reset state ----
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_product", 32'(bus.out_product), 32'd0);
    check("rst_start", 32'(mult_start), 32'd0);
    check("rst_mcand", 32'(mult_mcand), 32'd0);
    check("rst_mplier", 32'(mult_mplier), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_err", 32'(err_timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // ---- single job latency: 13*11 ----
    bus.in_valid = 1'b1;
    bus.in_a = 4'd13;
    bus.in_b = 4'd11;
    tick();                              // E0
    bus.in_valid = 1'b0;
    exp_q.push_back(8'd143);
    first_start = 0;
    for (n = 1; n < 40; n++) begin
      tick();
      if (mult_start && first_start == 0) first_start = n;
      if (n == 5) begin
        check("t1_mcand", 32'(mult_mcand), 32'd13);
        check("t1_mplier", 32'(mult_mplier), 32'd11);
      end
      if (bus.out_valid) break;
    end
    check("t1_start_edge", 32'(first_start), 32'd1);
    check("t1_latency", 32'(n), 32'd12);
    collect("t1_product");

    // ---- corner vectors back-to-back ----
    st0 = start_cnt;
    fork
      begin
        for (int i = 0; i < 6; i++) push(corner_v[i].a, corner_v[i].b, corner_v[i].p);
      end
      begin
        for (int i = 0; i < 6; i++) collect($sformatf("corner_%0d", i));
      end
    join
    check("corner_start_count", 32'(start_cnt - st0), 32'd6);
    check("corner_start_width", 32'(start_dbl), 32'd0);

    // ---- fill + backpressure ----
    for (int i = 0; i < 5; i++) push(fill_v[i].a, fill_v[i].b, fill_v[i].p);
    check("fill_count", 32'(fifo_count), 32'd4);
    check("fill_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a = 4'd3;
    bus.in_b = 4'd3;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    check("fill_ignored", 32'(fifo_count), 32'd4);
    wait_out_valid("bp");
    snap = bus.out_product;
    st0 = start_cnt;
    bad = 0;
    repeat (20) begin
      tick();
      if (!bus.out_valid || bus.out_product !== snap) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_no_start", 32'(start_cnt - st0), 32'd0);
    check("bp_state", 32'(dbg_state), 32'(ST_HOLD));
    for (int i = 0; i < 5; i++) collect($sformatf("fill_%0d", i));
    check("fill_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (30) tick();
    check("fill_no_extra", 32'(bus.out_valid), 32'd0);
    check("fill_start_width", 32'(start_dbl), 32'd0);

    // ---- lost done pulse ----
    drop_done = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 4'd9;
    bus.in_b = 4'd9;
    tick();                              // E0
    bus.in_valid = 1'b0;
    for (n = 1; n < 60; n++) begin
      tick();
      if (err_timeout) break;
    end
    check("to_edge", 32'(n), 32'd22);
    check("to_state", 32'(dbg_state), 32'(ST_IDLE));
    check("to_no_valid", 32'(bus.out_valid), 32'd0);
    drop_done = 1'b0;
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    repeat (3) tick();
    check("spur_idle_valid", 32'(bus.out_valid), 32'd0);
    check("spur_idle_state", 32'(dbg_state), 32'(ST_IDLE));
    push(4'd6, 4'd7, 8'd42);
    wait_out_valid("spur_hold");
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    tick();
    check("spur_hold_state", 32'(dbg_state), 32'(ST_HOLD));
    check("spur_hold_product", 32'(bus.out_product), 32'd42);
    collect("to_next_job");
    check("to_sticky", 32'(err_timeout), 32'd1);

    // ---- reset while in WAIT with 3 queued ----
    for (int i = 0; i < 4; i++) push(fill_v[i].a, fill_v[i].b, fill_v[i].p);
    exp_q.delete();
    for (n = 0; n < 50 && dbg_state != ST_WAIT; n++) tick();
    check("r6_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    check("r6_queued", 32'(fifo_count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r6_out_valid", 32'(bus.out_valid), 32'd0);
    check("r6_count", 32'(fifo_count), 32'd0);
    check("r6_in_ready", 32'(bus.in_ready), 32'd1);
    check("r6_err", 32'(err_timeout), 32'd0);
    check("r6_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (20) tick();
    check("r6_quiet_valid", 32'(bus.out_valid), 32'd0);
    check("r6_quiet_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
